// File: rtl/flappy_game_ctrl.sv
// flappy_game_ctrl
//   Game sequencer for the 16x16 LED matrix flappy game. Runs the
//   START -> PLAY -> OVER flow, produces the frame and gravity ticks that
//   pace the pipe scroller and the bird, detects collisions on the bird row
//   and keeps the score.
//
// Ports
//   Clock       system clock
//   RST         synchronous reset, active-high
//   flap        debounced single-cycle button pulse
//   birdie      bird row vector (one-hot, all-zero = bird off screen)
//   pipes       pipe matrix [row][col], 1 = pipe pixel
//   screen_sel  0 start screen, 1 play, 2 game over
//   play_en     high while playing; pipe/bird modules freeze when low
//   frame_tick  one pulse per frame period, PLAY only
//   grav_tick   one pulse every GRAV_FRAMES frame ticks, PLAY only
//   bird_up     flap qualified by PLAY
//   game_over   one pulse on the cycle PLAY is left because of a crash
//   score       pipes cleared, saturating; held until the next game starts
//
// All outputs are registered, so they reflect the inputs and state of the
// previous cycle.
module flappy_game_ctrl #(
  parameter int FRAME_DIV   = 25_000_000,
  parameter int GRAV_FRAMES = 2,
  parameter int HOLD_FRAMES = 8,
  parameter int BIRD_ROW    = 2,
  parameter int SCORE_W     = 8
) (
  input  logic                Clock,
  input  logic                RST,
  input  logic                flap,
  input  logic [15:0]         birdie,
  input  logic [15:0][15:0]   pipes,
  output logic [1:0]          screen_sel,
  output logic                play_en,
  output logic                frame_tick,
  output logic                grav_tick,
  output logic                bird_up,
  output logic                game_over,
  output logic [SCORE_W-1:0]  score
);

  localparam int DIV_W  = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam int GRAV_W = $clog2(GRAV_FRAMES + 1);
  localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

  localparam logic [DIV_W-1:0]   DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [GRAV_W-1:0]  GRAV_LAST = GRAV_W'(GRAV_FRAMES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_PLAY  = 2'd1,
    S_OVER  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [GRAV_W-1:0]   grav_q, grav_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [1:0]          screen_sel_q, screen_sel_d;
  logic                play_en_q, play_en_d;
  logic                frame_tick_q, frame_tick_d;
  logic                grav_tick_q, grav_tick_d;
  logic                bird_up_q, bird_up_d;
  logic                game_over_q, game_over_d;

  logic [15:0]         bird_row;
  logic                hit;
  logic                frame_end;
  logic [DIV_W-1:0]    div_next;

  // Only the bird's row matters here; the other rows feed the display path.
  logic unused_pipes;
  assign unused_pipes = ^pipes;

  assign bird_row  = pipes[BIRD_ROW];
  // A bird that has left the screen (all-zero vector) counts as a crash.
  assign hit       = (|(birdie & bird_row)) | (birdie == 16'h0000);
  assign frame_end = (div_q == DIV_LAST);
  assign div_next  = frame_end ? '0 : div_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    grav_d       = grav_q;
    hold_d       = hold_q;
    score_d      = score_q;
    frame_tick_d = 1'b0;
    grav_tick_d  = 1'b0;
    bird_up_d    = 1'b0;
    game_over_d  = 1'b0;

    case (state_q)
      S_START: begin
        // The starting flap only starts the game; it never lifts the bird.
        if (flap) begin
          state_d = S_PLAY;
          div_d   = '0;
          grav_d  = '0;
          hold_d  = '0;
          score_d = '0;
        end
      end

      S_PLAY: begin
        div_d = div_next;
        if (hit) begin
          // A crash beats everything else that would happen this cycle.
          state_d     = S_OVER;
          game_over_d = 1'b1;
        end else begin
          bird_up_d = flap;
          if (frame_end) begin
            frame_tick_d = 1'b1;
            if (grav_q == GRAV_LAST) begin
              grav_d      = '0;
              grav_tick_d = 1'b1;
            end else begin
              grav_d = grav_q + 1'b1;
            end
            if ((bird_row != 16'h0000) && (score_q != SCORE_MAX)) begin
              score_d = score_q + 1'b1;
            end
          end
        end
      end

      S_OVER: begin
        // Frame timing keeps running so the game-over screen is held for a
        // fixed number of frame periods before a flap is accepted.
        div_d = div_next;
        if (frame_end && (hold_q != HOLD_MAX)) begin
          hold_d = hold_q + 1'b1;
        end
        if (flap && (hold_q == HOLD_MAX)) begin
          state_d = S_START;
        end
      end

      default: state_d = S_START;
    endcase

    play_en_d = (state_d == S_PLAY);
    case (state_d)
      S_PLAY:  screen_sel_d = 2'd1;
      S_OVER:  screen_sel_d = 2'd2;
      default: screen_sel_d = 2'd0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (RST) begin
      state_q      <= S_START;
      div_q        <= '0;
      grav_q       <= '0;
      hold_q       <= '0;
      score_q      <= '0;
      screen_sel_q <= 2'd0;
      play_en_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      grav_tick_q  <= 1'b0;
      bird_up_q    <= 1'b0;
      game_over_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      grav_q       <= grav_d;
      hold_q       <= hold_d;
      score_q      <= score_d;
      screen_sel_q <= screen_sel_d;
      play_en_q    <= play_en_d;
      frame_tick_q <= frame_tick_d;
      grav_tick_q  <= grav_tick_d;
      bird_up_q    <= bird_up_d;
      game_over_q  <= game_over_d;
    end
  end

  assign screen_sel = screen_sel_q;
  assign play_en    = play_en_q;
  assign frame_tick = frame_tick_q;
  assign grav_tick  = grav_tick_q;
  assign bird_up    = bird_up_q;
  assign game_over  = game_over_q;
  assign score      = score_q;

endmodule

// File: tb/tb_flappy_game_ctrl.sv
module tb_flappy_game_ctrl;

  localparam int FD = 4;
  localparam int GF = 2;
  localparam int HF = 2;
  localparam int BR = 2;

  logic              Clock = 1'b0;
  logic              RST   = 1'b1;
  logic              flap  = 1'b0;
  logic [15:0]       birdie = 16'h0100;
  logic [15:0][15:0] pipes  = '0;

  logic [1:0] sel_a, sel_b;
  logic       play_a, ft_a, gt_a, up_a, go_a;
  logic       play_b, ft_b, gt_b, up_b, go_b;
  logic [7:0] score_a;
  logic [1:0] score_b;

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  always #5 Clock = ~Clock;

  flappy_game_ctrl #(.FRAME_DIV(FD), .GRAV_FRAMES(GF), .HOLD_FRAMES(HF),
                     .BIRD_ROW(BR), .SCORE_W(8)) dut_a (
    .Clock(Clock), .RST(RST), .flap(flap), .birdie(birdie), .pipes(pipes),
    .screen_sel(sel_a), .play_en(play_a), .frame_tick(ft_a), .grav_tick(gt_a),
    .bird_up(up_a), .game_over(go_a), .score(score_a));

  flappy_game_ctrl #(.FRAME_DIV(FD), .GRAV_FRAMES(GF), .HOLD_FRAMES(HF),
                     .BIRD_ROW(BR), .SCORE_W(2)) dut_b (
    .Clock(Clock), .RST(RST), .flap(flap), .birdie(birdie), .pipes(pipes),
    .screen_sel(sel_b), .play_en(play_b), .frame_tick(ft_b), .grav_tick(gt_b),
    .bird_up(up_b), .game_over(go_b), .score(score_b));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model. mode: 0 start, 1 play, 2 game over.
  // kp = PLAY cycles since the game started, ko = OVER cycles so far.
  // Frame periods are measured from the start of PLAY: PLAY cycle k ends a
  // frame when k is a multiple of FD; the frame counter keeps running in OVER.
  int mode = 0, kp = 0, ko = 0, score_m = 0, hold_m = 0;
  int e_sel = 0, e_play = 0, e_ft = 0, e_gt = 0, e_up = 0, e_go = 0;
  bit hit_m;

  always @(posedge Clock) begin
    e_ft = 0; e_gt = 0; e_up = 0; e_go = 0;
    if (RST) begin
      mode = 0; kp = 0; ko = 0; score_m = 0;
    end else begin
      hit_m = ((birdie & pipes[BR]) != 16'h0) || (birdie == 16'h0);
      case (mode)
        0: if (flap) begin mode = 1; kp = 0; score_m = 0; end
        1: begin
          kp++;
          if (hit_m) begin
            mode = 2; ko = 0; e_go = 1;
          end else begin
            e_up = flap;
            if (kp % FD == 0) begin
              e_ft = 1;
              e_gt = ((kp / FD) % GF == 0);
              if (pipes[BR] != 16'h0) score_m++;
            end
          end
        end
        default: begin
          ko++;
          hold_m = (kp + ko - 1) / FD - kp / FD;
          if (hold_m > HF) hold_m = HF;
          if (flap && hold_m >= HF) mode = 0;
        end
      endcase
    end
    e_sel  = mode;
    e_play = (mode == 1);
  end

  always @(negedge Clock) begin
    if (check_en) begin
      chk("screen_sel", sel_a, e_sel);
      chk("play_en", play_a, e_play);
      chk("frame_tick", ft_a, e_ft);
      chk("grav_tick", gt_a, e_gt);
      chk("bird_up", up_a, e_up);
      chk("game_over", go_a, e_go);
      chk("score", score_a, (score_m > 255) ? 255 : score_m);
      chk("screen_sel_w2", sel_b, e_sel);
      chk("score_w2", score_b, (score_m > 3) ? 3 : score_m);
    end
  end

  task automatic step();
    @(negedge Clock);
  endtask

  task automatic wait_frames(input int n);
    int seen = 0;
    int budget = 0;
    while (seen < n && budget < 100) begin
      step();
      budget++;
      if (ft_a) seen++;
    end
    chk("frame_wait_timeout", seen, n);
  endtask

  initial begin
    int cnt_ft, cnt_gt, cnt_any, r;
    @(posedge Clock);
    check_en = 1'b1;
    step();
    RST = 1'b0;

    // Idle on the start screen.
    cnt_any = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (ft_a || gt_a || play_a || up_a || go_a) cnt_any++;
    end
    chk("idle_sel", sel_a, 0);
    chk("idle_score", score_a, 0);
    chk("idle_activity", cnt_any, 0);

    // Start a game: bird on row bit 8, no pipes.
    flap = 1'b1;
    step();
    flap = 1'b0;
    chk("start_sel", sel_a, 1);
    chk("start_bird_up", up_a, 0);
    cnt_ft = 0; cnt_gt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (ft_a) cnt_ft++;
      if (gt_a) cnt_gt++;
    end
    chk("ticks_16cyc_frame", cnt_ft, 4);
    chk("ticks_16cyc_grav", cnt_gt, 2);

    // Three cleared pipes.
    pipes[BR] = 16'h00FF;
    wait_frames(3);
    chk("score_after_3", score_a, 3);

    // Crash exactly on a frame edge.
    step(); step(); step();
    pipes[BR] = 16'h0100;
    step();
    chk("crash_go", go_a, 1);
    chk("crash_sel", sel_a, 2);
    chk("crash_ft", ft_a, 0);
    chk("crash_score", score_a, 3);
    step();
    chk("crash_go_pulse", go_a, 0);

    // Early flap on the game-over screen is ignored, a later one returns.
    step(); step();
    flap = 1'b1;
    step();
    flap = 1'b0;
    chk("over_early_flap", sel_a, 2);
    step(); step(); step(); step();
    flap = 1'b1;
    step();
    flap = 1'b0;
    chk("over_late_flap", sel_a, 0);
    chk("over_score_kept", score_a, 3);

    // Saturation on the narrow-score instance, then reset mid-game.
    pipes[BR] = 16'h00FF;
    flap = 1'b1;
    step();
    flap = 1'b0;
    chk("game2_score_clear", score_a, 0);
    wait_frames(5);
    chk("sat_wide", score_a, 5);
    chk("sat_narrow", score_b, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_sel", sel_a, 0);
    chk("rst_score", score_a, 0);
    chk("rst_go", go_a, 0);

    // Randomised play.
    for (int i = 0; i < 3000; i++) begin
      flap = ($urandom_range(0, 5) == 0);
      RST  = ($urandom_range(0, 399) == 0);
      r = $urandom_range(0, 99);
      if (r < 97)      birdie = 16'h0100;
      else if (r < 98) birdie = 16'h0000;
      else             birdie = 16'(1 << $urandom_range(0, 15));
      for (int j = 0; j < 16; j++) pipes[j] = 16'($urandom);
      r = $urandom_range(0, 99);
      if (r < 50)      pipes[BR] = 16'h00FF;
      else if (r < 80) pipes[BR] = 16'h0000;
      else if (r < 98) pipes[BR] = 16'($urandom) & 16'hFEFF;
      else             pipes[BR] = 16'($urandom) | 16'h0100;
      step();
    end
    RST = 1'b0;
    flap = 1'b0;
    step();

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
